// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package hazard_pkg;
  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         CNT_W_DEF       = 16;
  localparam int         MEM_TIMEOUT_DEF = 64;
endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       count <= '0;
    else if (clr)                  count <= '0;
    else if (inc && count != '1)   count <= count + W'(1);
  end
endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage core: load-use bubbles, EX branch flushes,
// multi-cycle data-memory holds, plus a stall-cycle counter and sticky timeout flag.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RsIFID,
  input  logic [4:0]       RtIFID,
  input  logic             useRsIFID,
  input  logic             useRtIFID,
  input  logic             MemReadIDEX,
  input  logic [4:0]       RtIDEX,
  input  logic             branchTakenEX,
  input  logic             memReqEXMEM,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             pipeHold,
  output logic [CNT_W-1:0] stallCycles,
  output logic             memError
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic              mem_stall, load_use;
  logic [WAIT_W-1:0] wait_cnt;

  assign mem_stall = memReqEXMEM && !memReady;
  assign load_use  = MemReadIDEX && (RtIDEX != REG_ZERO) &&
                     ((useRsIFID && RsIFID == RtIDEX) || (useRtIFID && RtIFID == RtIDEX));

  // Memory hold outranks everything: a held branch/load-use is re-evaluated once it lifts.
  always_comb begin
    pcWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    pipeHold  = 1'b0;
    if (mem_stall) begin
      pcWrite   = 1'b0;
      IFIDWrite = 1'b0;
      pipeHold  = 1'b1;
    end else if (branchTakenEX) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (load_use) begin
      pcWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_stall) state_nxt = MEM_WAIT;
      MEM_WAIT: if (memReady || !memReqEXMEM) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pcWrite),
    .clr   (1'b0),
    .count (stallCycles)
  );

  // Counts consecutive stalled cycles; restarts whenever the FSM heads back to RUN.
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_stall),
    .clr   (state_nxt == RUN),
    .count (wait_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  memError <= 1'b0;
    else if (mem_stall && wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) memError <= 1'b1;
  end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; a narrow-counter instance shadows the main one for saturation.
module tb_hazard_stall_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  RsIFID, RtIFID, RtIDEX;
  logic        useRsIFID, useRtIFID, MemReadIDEX, branchTakenEX, memReqEXMEM, memReady;
  logic        pcWrite, IFIDWrite, IFIDFlush, IDEXFlush, pipeHold, memError;
  logic [15:0] stallCycles;
  logic        s_pcWrite, s_IFIDWrite, s_IFIDFlush, s_IDEXFlush, s_pipeHold, s_memError;
  logic [2:0]  s_stallCycles;

  int total = 0;
  int bad   = 0;
  int exp_sc = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.CNT_W(16), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .RsIFID(RsIFID), .RtIFID(RtIFID), .useRsIFID(useRsIFID),
    .useRtIFID(useRtIFID), .MemReadIDEX(MemReadIDEX), .RtIDEX(RtIDEX),
    .branchTakenEX(branchTakenEX), .memReqEXMEM(memReqEXMEM), .memReady(memReady),
    .pcWrite(pcWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
    .pipeHold(pipeHold), .stallCycles(stallCycles), .memError(memError)
  );

  hazard_stall_unit #(.CNT_W(3), .MEM_TIMEOUT(4)) dut_s (
    .clk(clk), .rst(rst), .RsIFID(RsIFID), .RtIFID(RtIFID), .useRsIFID(useRsIFID),
    .useRtIFID(useRtIFID), .MemReadIDEX(MemReadIDEX), .RtIDEX(RtIDEX),
    .branchTakenEX(branchTakenEX), .memReqEXMEM(memReqEXMEM), .memReady(memReady),
    .pcWrite(s_pcWrite), .IFIDWrite(s_IFIDWrite), .IFIDFlush(s_IFIDFlush),
    .IDEXFlush(s_IDEXFlush), .pipeHold(s_pipeHold), .stallCycles(s_stallCycles),
    .memError(s_memError)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RsIFID = 0; RtIFID = 0; RtIDEX = 0; useRsIFID = 0; useRtIFID = 0;
    MemReadIDEX = 0; branchTakenEX = 0; memReqEXMEM = 0; memReady = 0;
  endtask

  // {pcWrite, IFIDWrite, IFIDFlush, IDEXFlush, pipeHold}
  function automatic logic [4:0] ctl();
    return {pcWrite, IFIDWrite, IFIDFlush, IDEXFlush, pipeHold};
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    #2;
    chk("rst_ctl", 32'(ctl()), 32'b11000);
    chk("rst_sc", 32'(stallCycles), 0);
    chk("rst_err", 32'(memError), 0);
    // Outputs decode live inputs while reset is held; counters stay cleared.
    MemReadIDEX = 1; RtIDEX = 5'd8; RsIFID = 5'd8; useRsIFID = 1;
    #1;
    chk("rst_decode_lu", 32'(ctl()), 32'b00010);
    tick();
    chk("rst_sc_hold", 32'(stallCycles), 0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Load-use on rs
    MemReadIDEX = 1; RtIDEX = 5'd8; RsIFID = 5'd8; useRsIFID = 1;
    #1;
    chk("lu_ctl", 32'(ctl()), 32'b00010);
    tick(); exp_sc++;
    idle(); #1;
    chk("lu_sc", 32'(stallCycles), 32'(exp_sc));
    chk("lu_after", 32'(ctl()), 32'b11000);

    // r0 never hazards
    MemReadIDEX = 1; RtIDEX = 5'd0; RsIFID = 5'd0; useRsIFID = 1;
    #1;
    chk("zero_reg", 32'(ctl()), 32'b11000);
    // Matching rt but not read
    RtIDEX = 5'd9; RtIFID = 5'd9; RsIFID = 5'd3; useRsIFID = 0; useRtIFID = 0;
    #1;
    chk("unused_rt", 32'(ctl()), 32'b11000);
    useRtIFID = 1;
    #1;
    chk("used_rt", 32'(ctl()), 32'b00010);
    tick(); exp_sc++;
    idle(); #1;
    chk("used_rt_sc", 32'(stallCycles), 32'(exp_sc));

    // Branch beats load-use
    MemReadIDEX = 1; RtIDEX = 5'd8; RsIFID = 5'd8; useRsIFID = 1; branchTakenEX = 1;
    #1;
    chk("br_ctl", 32'(ctl()), 32'b11110);
    tick();
    idle(); #1;
    chk("br_sc", 32'(stallCycles), 32'(exp_sc));

    // Ready with request: no stall
    memReqEXMEM = 1; memReady = 1;
    #1;
    chk("mem_fast", 32'(ctl()), 32'b11000);
    tick();
    chk("mem_fast_sc", 32'(stallCycles), 32'(exp_sc));

    // 3-cycle wait with a branch held across it
    memReqEXMEM = 1; memReady = 0; branchTakenEX = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("wait%0d_ctl", i), 32'(ctl()), 32'b00001);
      tick(); exp_sc++;
    end
    memReady = 1;
    #1;
    chk("wait_done_br", 32'(ctl()), 32'b11110);
    chk("wait_sc", 32'(stallCycles), 32'(exp_sc));
    tick();
    idle(); #1;
    chk("wait_err", 32'(memError), 0);

    // Timeout: 6 wait cycles, error after the 4th
    memReqEXMEM = 1; memReady = 0;
    for (int i = 1; i <= 6; i++) begin
      tick(); exp_sc++;
      chk($sformatf("to_err%0d", i), 32'(memError), (i >= 4) ? 1 : 0);
    end
    memReady = 1;
    tick();
    idle(); tick();
    chk("to_sticky", 32'(memError), 1);
    chk("to_sc", 32'(stallCycles), 32'(exp_sc));
    chk("sat_sc", 32'(s_stallCycles), 32'((exp_sc > 7) ? 7 : exp_sc));

    // Reset in the 2nd wait cycle acts before the next edge
    memReqEXMEM = 1; memReady = 0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sc", 32'(stallCycles), 0);
    chk("arst_err", 32'(memError), 0);
    chk("arst_sat_sc", 32'(s_stallCycles), 0);
    chk("arst_hold", 32'(pipeHold), 1);
    idle();
    @(negedge clk);
    rst = 1'b0;
    exp_sc = 0;

    // Wait counter must be clear: a 3-cycle wait stays under timeout
    tick();
    memReqEXMEM = 1; memReady = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); exp_sc++;
    end
    memReady = 1;
    tick();
    idle(); #1;
    chk("post_rst_err", 32'(memError), 0);
    chk("post_rst_sc", 32'(stallCycles), 32'(exp_sc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
